// File: rtl/mipi_lane_pkg.sv
// Shared definitions for the MIPI lane receive path.
//   lane_state_e     : alignment FSM states (HUNT, LOCKED)
//   MIPI_HS_SYNC     : HS leader/sync byte used as the default alignment word
//   ORDER_*          : bit-order selectors for the LSB_FIRST parameter
package mipi_lane_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lane_state_e;

  localparam logic [7:0] MIPI_HS_SYNC = 8'hB8;

  localparam bit ORDER_LSB_FIRST = 1'b1;
  localparam bit ORDER_MSB_FIRST = 1'b0;

endpackage

// File: rtl/mipi_bit_shifter.sv
// Serial shift register with a look-ahead window.
//   clk, rst : bit clock, synchronous active-high reset
//   en       : shift din in on this edge
//   clr      : empty the register (takes priority over en)
//   din      : serial bit
//   window   : register contents as they will be after din is shifted in,
//              so the parent can compare/capture a full word on the same
//              edge that samples its last bit
module mipi_bit_shifter
  import mipi_lane_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] window
);

  logic [WIDTH-1:0] sh;

  // LSB-first: new bits enter at the top and walk down, so the first bit of a
  // word ends up in bit 0. MSB-first: new bits enter at bit 0 and walk up.
  always_comb begin
    if (LSB_FIRST == ORDER_LSB_FIRST) window = {din, sh[WIDTH-1:1]};
    else                              window = {sh[WIDTH-2:0], din};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and checked first so it wins.
  always_ff @(posedge clk) begin
    if (rst || clr) sh <= '0;
    else if (en)    sh <= window;
  end

endmodule

// File: rtl/mipi_sync_deserializer.sv
// 1:WIDTH serial-to-parallel converter with sync-word alignment.
//   clk       : bit clock, one bit per edge while validIn=1
//   rst       : synchronous, active-high reset
//   datain    : serial data bit
//   validIn   : high for the whole burst; low = end of burst
//   dataout   : last aligned word, held until the next one
//   validOut  : one-cycle pulse, dataout holds a new word
//   syncDet   : one-cycle pulse, sync word matched and lane locked
//   locked    : high while the lane is aligned
//   wordCnt   : words emitted in the current burst, saturating
module mipi_sync_deserializer
  import mipi_lane_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter bit               LSB_FIRST = ORDER_LSB_FIRST,
  parameter bit               SYNC_EN   = 1'b1,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(MIPI_HS_SYNC),
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             datain,
  input  logic             validIn,
  output logic [WIDTH-1:0] dataout,
  output logic             validOut,
  output logic             syncDet,
  output logic             locked,
  output logic [CNT_W-1:0] wordCnt
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  // Without sync hunting the lane is permanently aligned, so HUNT is never used.
  localparam lane_state_e RESET_STATE = SYNC_EN ? HUNT : LOCKED;
  localparam lane_state_e IDLE_STATE  = SYNC_EN ? HUNT : LOCKED;

  lane_state_e      state, state_next;
  logic [BIT_W-1:0] bit_cnt;
  // Bits seen in the current hunt, saturating at WIDTH-1: once saturated the
  // incoming bit completes a full window and a compare is meaningful.
  logic [BIT_W-1:0] fill_cnt;
  logic             valid_q;
  logic [WIDTH-1:0] window;
  logic             sync_hit;
  logic             word_done;

  mipi_bit_shifter #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .en     (validIn),
    .clr    (!validIn),
    .din    (datain),
    .window (window)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (!validIn)                        state_next = IDLE_STATE;
    else if (state == HUNT && sync_hit)  state_next = LOCKED;
  end

  // Per-bit decode: sync match while hunting, word completion while locked
  always_comb begin
    sync_hit  = 1'b0;
    word_done = 1'b0;
    if (validIn) begin
      if (state == HUNT) sync_hit = SYNC_EN && (fill_cnt == LAST_BIT) && (window == SYNC_WORD);
      else               word_done = (bit_cnt == LAST_BIT);
    end
  end

  // Counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      fill_cnt <= '0;
      valid_q  <= 1'b0;
      dataout  <= '0;
      validOut <= 1'b0;
      syncDet  <= 1'b0;
      locked   <= 1'b0;
      wordCnt  <= '0;
    end else begin
      valid_q  <= validIn;
      syncDet  <= sync_hit;
      validOut <= word_done;
      locked   <= (state_next == LOCKED);

      if (!validIn) begin
        // End of burst: drop any partial word and restart alignment.
        bit_cnt  <= '0;
        fill_cnt <= '0;
      end else if (state == HUNT) begin
        bit_cnt <= '0;
        if (fill_cnt != LAST_BIT) fill_cnt <= fill_cnt + 1'b1;
      end else begin
        fill_cnt <= '0;
        bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
      end

      if (word_done) dataout <= window;

      // A burst start cannot also complete a word (WIDTH >= 2), so the clear
      // and the increment never collide.
      if (validIn && !valid_q)               wordCnt <= '0;
      else if (word_done && wordCnt != '1)   wordCnt <= wordCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mipi_sync_deserializer.sv
// Self-checking bench: four deserializer instances with different parameter
// sets, a queue-based reference model, a per-cycle compare process and a set
// of hand-computed expectations for the directed scenarios.
module tb_mipi_sync_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din [4];
  logic vin [4];

  always #5 clk = ~clk;

  // Instance 0: defaults. 1: 10-bit MSB-first. 2: free-run. 3: 2-bit free-run, 2-bit counter.
  logic [7:0]  dout0, dout2;
  logic [9:0]  dout1;
  logic [1:0]  dout3;
  logic [15:0] wc0, wc1, wc2;
  logic [1:0]  wc3;
  logic        vo [4];
  logic        sd [4];
  logic        lk [4];

  mipi_sync_deserializer u_dut0 (
    .clk(clk), .rst(rst), .datain(din[0]), .validIn(vin[0]), .dataout(dout0),
    .validOut(vo[0]), .syncDet(sd[0]), .locked(lk[0]), .wordCnt(wc0));

  mipi_sync_deserializer #(.WIDTH(10), .LSB_FIRST(1'b0), .SYNC_WORD(10'h17C)) u_dut1 (
    .clk(clk), .rst(rst), .datain(din[1]), .validIn(vin[1]), .dataout(dout1),
    .validOut(vo[1]), .syncDet(sd[1]), .locked(lk[1]), .wordCnt(wc1));

  mipi_sync_deserializer #(.SYNC_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .datain(din[2]), .validIn(vin[2]), .dataout(dout2),
    .validOut(vo[2]), .syncDet(sd[2]), .locked(lk[2]), .wordCnt(wc2));

  mipi_sync_deserializer #(.WIDTH(2), .SYNC_EN(1'b0), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .datain(din[3]), .validIn(vin[3]), .dataout(dout3),
    .validOut(vo[3]), .syncDet(sd[3]), .locked(lk[3]), .wordCnt(wc3));

  logic [15:0] a_dout [4];
  logic [15:0] a_wc   [4];
  assign a_dout[0] = 16'(dout0);
  assign a_dout[1] = 16'(dout1);
  assign a_dout[2] = 16'(dout2);
  assign a_dout[3] = 16'(dout3);
  assign a_wc[0]   = wc0;
  assign a_wc[1]   = wc1;
  assign a_wc[2]   = wc2;
  assign a_wc[3]   = 16'(wc3);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          p_w   [4] = '{8, 10, 8, 2};
  bit          p_lf  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          p_se  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [15:0] p_sw  [4] = '{16'h00B8, 16'h017C, 16'h00B8, 16'h0000};
  logic [15:0] p_cap [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0003};

  bit          hunt_q [4][$];   // recent bits while looking for the sync word
  bit          word_q [4][$];   // bits of the word being collected
  bit          aligned [4];
  bit          prev_v  [4];
  logic [15:0] e_dout [4];
  logic [15:0] e_wc   [4];
  logic        e_vo   [4];
  logic        e_sd   [4];
  logic        e_lk   [4];

  // k-th received bit lands at position k (LSB first) or w-1-k (MSB first).
  function automatic logic [15:0] assemble(input int w, input bit lf, input bit bits[$]);
    logic [15:0] v = '0;
    for (int k = 0; k < w; k++) begin
      if (lf) v[k] = bits[k];
      else    v[w-1-k] = bits[k];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      e_vo[i] = 1'b0;
      e_sd[i] = 1'b0;
      if (rst) begin
        hunt_q[i].delete();
        word_q[i].delete();
        aligned[i] = !p_se[i];
        prev_v[i]  = 1'b0;
        e_dout[i]  = '0;
        e_wc[i]    = '0;
        e_lk[i]    = 1'b0;
      end else begin
        if (!vin[i]) begin
          hunt_q[i].delete();
          word_q[i].delete();
          aligned[i] = !p_se[i];
        end else begin
          if (!prev_v[i]) e_wc[i] = '0;
          if (!aligned[i]) begin
            hunt_q[i].push_back(din[i]);
            if (hunt_q[i].size() > p_w[i]) void'(hunt_q[i].pop_front());
            if (hunt_q[i].size() == p_w[i] && assemble(p_w[i], p_lf[i], hunt_q[i]) == p_sw[i]) begin
              aligned[i] = 1'b1;
              e_sd[i]    = 1'b1;
              hunt_q[i].delete();
              word_q[i].delete();
            end
          end else begin
            word_q[i].push_back(din[i]);
            if (word_q[i].size() == p_w[i]) begin
              e_dout[i] = assemble(p_w[i], p_lf[i], word_q[i]);
              e_vo[i]   = 1'b1;
              if (e_wc[i] != p_cap[i]) e_wc[i] = e_wc[i] + 16'd1;
              word_q[i].delete();
            end
          end
        end
        prev_v[i] = vin[i];
        e_lk[i]   = aligned[i];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  int vo_seen [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("dataout[%0d]", i),  a_dout[i], e_dout[i]);
        check($sformatf("validOut[%0d]", i), vo[i],     e_vo[i]);
        check($sformatf("syncDet[%0d]", i),  sd[i],     e_sd[i]);
        check($sformatf("locked[%0d]", i),   lk[i],     e_lk[i]);
        check($sformatf("wordCnt[%0d]", i),  a_wc[i],   e_wc[i]);
        check($sformatf("pulse_excl[%0d]", i), vo[i] & sd[i], 1'b0);
        if (vo[i] === 1'b1) vo_seen[i]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int i, input logic [15:0] val, input int n, input bit lf);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      din[i] = lf ? val[k] : val[n-1-k];
      vin[i] = 1'b1;
    end
  endtask

  task automatic idle(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      vin[i] = 1'b0;
      din[i] = 1'b0;
    end
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    for (int i = 0; i < 4; i++) begin
      din[i] = 1'b0;
      vin[i] = 1'b0;
    end
    after_edge;
    chk_en = 1'b1;
    repeat (2) after_edge;
    check("reset dataout",  32'(dout0), 32'h0);
    check("reset validOut", vo[0], 1'b0);
    check("reset syncDet",  sd[0], 1'b0);
    check("reset locked",   lk[0], 1'b0);
    check("reset wordCnt",  32'(wc0), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: sync 0xB8 LSB-first
    send(0, 16'h00B8, 8, 1'b1);
    after_edge;
    check("t1 syncDet", sd[0], 1'b1);
    check("t1 locked",  lk[0], 1'b1);

    // 2: first data word
    send(0, 16'h005A, 8, 1'b1);
    after_edge;
    check("t2 validOut", vo[0], 1'b1);
    check("t2 dataout",  32'(dout0), 32'h5A);
    check("t2 wordCnt",  32'(wc0), 32'h1);
    idle(0, 3);
    after_edge;
    check("t2 unlocked", lk[0], 1'b0);
    check("t2 held",     32'(dout0), 32'h5A);

    // 3: junk before sync is never emitted
    vo_seen[0] = 0;
    send(0, 16'h00FF, 8, 1'b1);
    send(0, 16'h00B8, 8, 1'b1);
    after_edge;
    check("t3 syncDet",  sd[0], 1'b1);
    check("t3 no early", vo_seen[0], 0);
    send(0, 16'h003C, 8, 1'b1);
    after_edge;
    check("t3 dataout", 32'(dout0), 32'h3C);
    check("t3 wordCnt", 32'(wc0), 32'h1);

    // 4: partial word dropped at end of burst, then relock
    send(0, 16'h0015, 5, 1'b1);
    idle(0, 2);
    after_edge;
    check("t4 unlocked",   lk[0], 1'b0);
    check("t4 one pulse",  vo_seen[0], 1);
    check("t4 held",       32'(dout0), 32'h3C);
    send(0, 16'h00B8, 8, 1'b1);
    send(0, 16'h00A5, 8, 1'b1);
    after_edge;
    check("t4 dataout", 32'(dout0), 32'hA5);
    check("t4 wordCnt", 32'(wc0), 32'h1);
    idle(0, 2);

    // 5: 10-bit MSB-first
    send(1, 16'h017C, 10, 1'b0);
    after_edge;
    check("t5 syncDet", sd[1], 1'b1);
    send(1, 16'h02B3, 10, 1'b0);
    after_edge;
    check("t5 validOut", vo[1], 1'b1);
    check("t5 dataout",  32'(dout1), 32'h2B3);
    idle(1, 2);

    // 6: free-run, then reset mid-word
    check("t6 locked", lk[2], 1'b1);
    send(2, 16'h00C3, 8, 1'b1);
    after_edge;
    check("t6 dataout", 32'(dout2), 32'hC3);
    check("t6 wordCnt", 32'(wc2), 32'h1);
    send(2, 16'h0005, 3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    after_edge;
    check("t6 rst dataout",  32'(dout2), 32'h0);
    check("t6 rst validOut", vo[2], 1'b0);
    check("t6 rst syncDet",  sd[2], 1'b0);
    check("t6 rst locked",   lk[2], 1'b0);
    check("t6 rst wordCnt",  32'(wc2), 32'h0);
    check("t6 rst dataout0", 32'(dout0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2, 2);

    // 7: WIDTH=2 words 01,10,11,00,01 in one burst; 2-bit counter saturates
    send(3, 16'h0139, 10, 1'b1);
    after_edge;
    check("t7 dataout", 32'(dout3), 32'h1);
    check("t7 wordCnt", 32'(wc3), 32'h3);
    idle(3, 3);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
